// File: rtl/alu_issue_ctrl_if.sv
// Bundles the instruction, ALU-drive, ALU-return, retire and debug signals of alu_issue_ctrl.
// The controller uses the slave modport; the instruction source/ALU side uses master.
interface alu_issue_ctrl_if;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] instr_op;
   logic [1:0] instr_rd;
   logic [1:0] instr_rs1;
   logic [1:0] instr_rs2;
   logic [7:0] instr_imm;
   logic       instr_use_imm;

   logic [3:0] alu_opcode;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic       alu_s;
   logic       alu_z;
   logic       alu_p;

   logic       done_valid;
   logic [7:0] done_result;
   logic       done_err;
   logic [3:0] flags;

   logic [1:0] dbg_addr;
   logic [7:0] dbg_data;

   modport slave (
      input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm, instr_use_imm,
      input  alu_result, alu_carry, alu_s, alu_z, alu_p, dbg_addr,
      output instr_ready, alu_opcode, alu_a, alu_b,
      output done_valid, done_result, done_err, flags, dbg_data
   );

   modport master (
      output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm, instr_use_imm,
      output alu_result, alu_carry, alu_s, alu_z, alu_p, dbg_addr,
      input  instr_ready, alu_opcode, alu_a, alu_b,
      input  done_valid, done_result, done_err, flags, dbg_data
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Two-state issue controller for the 8-bit ALU: latches an instruction and its operands,
// drives the ALU for one cycle, then retires the result into the register file and flags.
module alu_issue_ctrl (
   input  logic           clk,
   input  logic           rst,
   alu_issue_ctrl_if.slave bus
);
   localparam int unsigned DATA_W = 8;
   localparam int unsigned NREG   = 4;

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e            state_q;
   logic [3:0]        op_q;
   logic [1:0]        rd_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] regs_q [NREG];
   logic [3:0]        flags_q;
   logic              done_valid_q;
   logic              done_err_q;
   logic [DATA_W-1:0] done_result_q;
   logic              issue_err;

   // Rejected: undefined opcodes and divide by zero.
   assign issue_err = (op_q > 4'd9) || ((op_q == 4'd3) && (b_q == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         op_q          <= '0;
         rd_q          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         regs_q        <= '{default: '0};
         flags_q       <= '0;
         done_valid_q  <= 1'b0;
         done_err_q    <= 1'b0;
         done_result_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               done_valid_q <= 1'b0;
               if (bus.instr_valid) begin
                  op_q    <= bus.instr_op;
                  rd_q    <= bus.instr_rd;
                  a_q     <= regs_q[bus.instr_rs1];
                  b_q     <= bus.instr_use_imm ? bus.instr_imm : regs_q[bus.instr_rs2];
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               done_valid_q <= 1'b1;
               state_q      <= StIdle;
               if (issue_err) begin
                  done_err_q    <= 1'b1;
                  done_result_q <= '0;
               end else begin
                  regs_q[rd_q]  <= bus.alu_result;
                  done_err_q    <= 1'b0;
                  done_result_q <= bus.alu_result;
                  flags_q[2:0]  <= {bus.alu_s, bus.alu_z, bus.alu_p};
                  // Carry is sticky across logic and shift ops.
                  if (op_q < 4'd4) begin
                     flags_q[3] <= bus.alu_carry;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.instr_ready = (state_q == StIdle);
   assign bus.alu_opcode  = op_q;
   assign bus.alu_a       = a_q;
   assign bus.alu_b       = b_q;
   assign bus.done_valid  = done_valid_q;
   assign bus.done_result = done_result_q;
   assign bus.done_err    = done_err_q;
   assign bus.flags       = flags_q;
   assign bus.dbg_data    = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: supplies a behavioural ALU, runs a directed vector
// table, random instructions against a reference model, and hand-written timing sequences.
module tb_alu_issue_ctrl;
   logic clk = 1'b0;
   logic rst;

   alu_issue_ctrl_if bus ();

   alu_issue_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mregs [4];
   logic [3:0] mflags;

   typedef struct {
      logic [3:0] op;
      logic [1:0] rd;
      logic [1:0] rs1;
      logic [1:0] rs2;
      logic [7:0] imm;
      logic       use_imm;
      logic [7:0] res;
      logic       err;
      logic [3:0] fl;
   } vec_t;

   vec_t tbl [14];

   // Behavioural ALU: {carry, result}. Logic/shift ops report carry=1 so a non-sticky C shows up.
   function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, b);
      logic [15:0] w;
      logic        c;
      c = 1'b1;
      case (op)
         4'd0: begin w = {8'h00, a} + {8'h00, b}; c = w[8]; end
         4'd1: begin w = {8'h00, a} - {8'h00, b}; c = (a < b); end
         4'd2: begin w = {8'h00, a} * {8'h00, b}; c = (w[15:8] != 8'h00); end
         4'd3: begin w = (b == 8'h00) ? 16'h00FF : {8'h00, a / b}; c = 1'b0; end
         4'd4: w = {8'h00, a & b};
         4'd5: w = {8'h00, a | b};
         4'd6: w = {8'h00, ~a};
         4'd7: w = {8'h00, a ^ b};
         4'd8: w = {8'h00, a} << b;
         4'd9: w = {8'h00, a} >> b;
         default: w = 16'h00AA;
      endcase
      return {c, w[7:0]};
   endfunction

   logic [8:0] alu_out;
   assign alu_out        = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);
   assign bus.alu_result = alu_out[7:0];
   assign bus.alu_carry  = alu_out[8];
   assign bus.alu_s      = alu_out[7];
   assign bus.alu_z      = (alu_out[7:0] == 8'h00);
   assign bus.alu_p      = ~^alu_out[7:0];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what retiring this instruction should produce from the current model state.
   task automatic model_predict(input logic [3:0] op, input logic [1:0] rs1, rs2,
                                input logic [7:0] imm, input logic use_imm,
                                output logic [7:0] res, output logic err, output logic [3:0] fl);
      logic [7:0] b;
      logic [8:0] o;
      b = use_imm ? imm : mregs[rs2];
      if (op > 4'd9 || (op == 4'd3 && b == 8'h00)) begin
         res = 8'h00;
         err = 1'b1;
         fl  = mflags;
      end else begin
         o   = alu_fn(op, mregs[rs1], b);
         res = o[7:0];
         err = 1'b0;
         fl  = {(op < 4'd4) ? o[8] : mflags[3], o[7], o[7:0] == 8'h00, ~^o[7:0]};
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 4; r++) mregs[r] = 8'h00;
      mflags = 4'b0000;
   endtask

   task automatic check_regs(input string name);
      for (int r = 0; r < 4; r++) begin
         bus.dbg_addr = 2'(r);
         #1;
         check(name, bus.dbg_data, mregs[r]);
      end
   endtask

   // One full instruction: handshake, ALU-drive cycle, retire cycle, register readback.
   task automatic run_instr(input logic [3:0] op, input logic [1:0] rd, rs1, rs2,
                            input logic [7:0] imm, input logic use_imm,
                            input logic [7:0] exp_res, input logic exp_err,
                            input logic [3:0] exp_fl);
      logic [7:0] exp_a, exp_b, mres;
      logic       merr;
      logic [3:0] mfl;
      exp_a = mregs[rs1];
      exp_b = use_imm ? imm : mregs[rs2];
      @(negedge clk);
      check("ready_before_issue", bus.instr_ready, 1);
      bus.instr_op      = op;
      bus.instr_rd      = rd;
      bus.instr_rs1     = rs1;
      bus.instr_rs2     = rs2;
      bus.instr_imm     = imm;
      bus.instr_use_imm = use_imm;
      bus.instr_valid   = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.instr_op    = ~op;
      bus.instr_rs1   = ~rs1;
      bus.instr_imm   = ~imm;
      @(negedge clk);
      check("ready_in_issue", bus.instr_ready, 0);
      check("done_valid_in_issue", bus.done_valid, 0);
      check("alu_opcode", bus.alu_opcode, op);
      check("alu_a", bus.alu_a, exp_a);
      check("alu_b", bus.alu_b, exp_b);
      @(negedge clk);
      check("done_valid", bus.done_valid, 1);
      check("ready_at_retire", bus.instr_ready, 1);
      check("done_result", bus.done_result, exp_res);
      check("done_err", bus.done_err, exp_err);
      check("flags", bus.flags, exp_fl);
      model_predict(op, rs1, rs2, imm, use_imm, mres, merr, mfl);
      if (!merr) mregs[rd] = mres;
      mflags = mfl;
      check_regs("regfile");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r_res;
      logic       r_err;
      logic [3:0] r_fl;
      logic [3:0] op;

      tbl[0]  = '{4'd0,  2'd1, 2'd0, 2'd0, 8'h05, 1'b1, 8'h05, 1'b0, 4'b0001};
      tbl[1]  = '{4'd0,  2'd1, 2'd0, 2'd0, 8'hFF, 1'b1, 8'hFF, 1'b0, 4'b0101};
      tbl[2]  = '{4'd0,  2'd2, 2'd1, 2'd0, 8'h01, 1'b1, 8'h00, 1'b0, 4'b1011};
      tbl[3]  = '{4'd1,  2'd3, 2'd2, 2'd0, 8'h01, 1'b1, 8'hFF, 1'b0, 4'b1101};
      tbl[4]  = '{4'd7,  2'd1, 2'd3, 2'd0, 8'h0F, 1'b1, 8'hF0, 1'b0, 4'b1101};
      tbl[5]  = '{4'd4,  2'd2, 2'd1, 2'd0, 8'h0F, 1'b1, 8'h00, 1'b0, 4'b1011};
      tbl[6]  = '{4'd5,  2'd3, 2'd0, 2'd0, 8'h81, 1'b1, 8'h81, 1'b0, 4'b1101};
      tbl[7]  = '{4'd8,  2'd3, 2'd3, 2'd0, 8'h01, 1'b1, 8'h02, 1'b0, 4'b1000};
      tbl[8]  = '{4'd12, 2'd1, 2'd0, 2'd0, 8'h33, 1'b1, 8'h00, 1'b1, 4'b1000};
      tbl[9]  = '{4'd3,  2'd1, 2'd1, 2'd0, 8'h00, 1'b0, 8'h00, 1'b1, 4'b1000};
      tbl[10] = '{4'd2,  2'd0, 2'd1, 2'd0, 8'h03, 1'b1, 8'hD0, 1'b0, 4'b1100};
      tbl[11] = '{4'd3,  2'd2, 2'd0, 2'd0, 8'h07, 1'b1, 8'h1D, 1'b0, 4'b0001};
      tbl[12] = '{4'd6,  2'd1, 2'd2, 2'd0, 8'h00, 1'b1, 8'hE2, 1'b0, 4'b0101};
      tbl[13] = '{4'd9,  2'd3, 2'd1, 2'd0, 8'h04, 1'b1, 8'h0E, 1'b0, 4'b0000};

      rst               = 1'b1;
      bus.instr_valid   = 1'b0;
      bus.instr_op      = '0;
      bus.instr_rd      = '0;
      bus.instr_rs1     = '0;
      bus.instr_rs2     = '0;
      bus.instr_imm     = '0;
      bus.instr_use_imm = 1'b0;
      bus.dbg_addr      = '0;
      model_reset();

      #3;
      check("rst_ready", bus.instr_ready, 1);
      check("rst_flags", bus.flags, 0);
      check("rst_done_valid", bus.done_valid, 0);
      check("rst_done_result", bus.done_result, 0);
      check("rst_done_err", bus.done_err, 0);
      check("rst_alu_opcode", bus.alu_opcode, 0);
      check("rst_alu_a", bus.alu_a, 0);
      check("rst_alu_b", bus.alu_b, 0);
      check_regs("rst_regfile");
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         run_instr(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].use_imm,
                   tbl[i].res, tbl[i].err, tbl[i].fl);
      end

      for (int n = 0; n < 60; n++) begin
         logic [1:0] rd, rs1, rs2;
         logic [7:0] imm;
         logic       use_imm;
         op      = 4'($urandom_range(0, 11));
         rd      = 2'($urandom_range(0, 3));
         rs1     = 2'($urandom_range(0, 3));
         rs2     = 2'($urandom_range(0, 3));
         imm     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         use_imm = 1'($urandom);
         model_predict(op, rs1, rs2, imm, use_imm, r_res, r_err, r_fl);
         run_instr(op, rd, rs1, rs2, imm, use_imm, r_res, r_err, r_fl);
      end

      // Back-to-back with instr_valid held high; fields change while not ready and must be ignored.
      @(negedge clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("b2b_ready", bus.instr_ready, (i == 6) || (i % 2 == 0));
         check("b2b_done_valid", bus.done_valid, (i >= 2) && (i % 2 == 0));
         if (i == 2) check("b2b_result0", bus.done_result, 8'h03);
         if (i == 4) check("b2b_result1", bus.done_result, 8'h06);
         if (i == 6) check("b2b_result2", bus.done_result, 8'h05);
         case (i)
            0: begin
               bus.instr_op = 4'd0; bus.instr_rd = 2'd1; bus.instr_rs1 = 2'd0;
               bus.instr_imm = 8'h03; bus.instr_use_imm = 1'b1; bus.instr_valid = 1'b1;
            end
            1: begin
               bus.instr_op = 4'd0; bus.instr_rd = 2'd2; bus.instr_rs1 = 2'd1;
               bus.instr_rs2 = 2'd1; bus.instr_use_imm = 1'b0;
            end
            3: begin
               bus.instr_op = 4'd1; bus.instr_rd = 2'd3; bus.instr_rs1 = 2'd2;
               bus.instr_imm = 8'h01; bus.instr_use_imm = 1'b1;
            end
            5: bus.instr_valid = 1'b0;
            default: ;
         endcase
      end
      mregs[1] = 8'h03;
      mregs[2] = 8'h06;
      mregs[3] = 8'h05;
      check("b2b_flags", bus.flags, 4'b0001);
      check_regs("b2b_regfile");

      // Reset in the middle of ISSUE: no retire, everything cleared.
      @(negedge clk);
      bus.instr_op = 4'd0; bus.instr_rd = 2'd0; bus.instr_rs1 = 2'd2;
      bus.instr_imm = 8'h01; bus.instr_use_imm = 1'b1; bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      check("pre_rst_ready", bus.instr_ready, 0);
      rst = 1'b1;
      #1;
      check("midrst_ready", bus.instr_ready, 1);
      check("midrst_alu_a", bus.alu_a, 0);
      #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("midrst_done_valid", bus.done_valid, 0);
         check("midrst_flags", bus.flags, 0);
      end
      check_regs("midrst_regfile");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
